ex_muldiv: RTL and testbench

Multi-cycle multiply/divide unit next to the EX stage. It replaces single-cycle combinational `*`, `/` and `%` for Mult, Multu, Div and Divu with an iterative datapath of parametrised width that completes one bit per cycle. While it runs it stalls the pipeline. It delivers HI/LO write-backs through the existing `whi`/`wlo` interface. It supports flush on exception and defines divide-by-zero behaviour.

---
 rtl/ex_muldiv_pkg.sv | 29 ++
 rtl/ex_muldiv_if.sv | 26 ++
 rtl/ex_muldiv_md_negate.sv | 11 +
 rtl/ex_muldiv.sv | 143 ++++++++++++++
 tb/tb_ex_muldiv.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// controller states and the divide-by-zero LO fill.
package ex_muldiv_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      MDS_IDLE = 2'd0,
      MDS_CALC = 2'd1,
      MDS_DONE = 2'd2
   } md_state_e;

   // LO on divide-by-zero is this bit replicated across the operand width.
   localparam logic MD_DIV0_LO_BIT = 1'b1;

   function automatic logic md_is_div(md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX stage (master) and the mul/div unit (slave).
interface ex_muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start_i;
   logic [1:0]       mdop_i;
   logic [WIDTH-1:0] regaData;
   logic [WIDTH-1:0] regbData;
   logic             cancel_i;
   logic             stall_o;
   logic             done_o;
   logic             whi;
   logic             wlo;
   logic [WIDTH-1:0] wHiData;
   logic [WIDTH-1:0] wLoData;

   modport master (
      output start_i, mdop_i, regaData, regbData, cancel_i,
      input  stall_o, done_o, whi, wlo, wHiData, wLoData
   );

   modport slave (
      input  start_i, mdop_i, regaData, regbData, cancel_i,
      output stall_o, done_o, whi, wlo, wHiData, wLoData
   );
endinterface

// File: rtl/ex_muldiv_md_negate.sv
// Conditional two's-complement negator, used for operand magnitudes and
// for sign-correcting results.
module md_negate #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);
   assign dout_o = en_i ? (WIDTH'(0) - din_i) : din_i;
endmodule

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, sign fixed up on the way out.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave md
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   md_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               neg_lo_q, neg_lo_d;  // product / quotient sign
   logic               neg_hi_q, neg_hi_d;  // remainder sign
   logic [WIDTH-1:0]   mcand_q, mcand_d;    // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH:0]     rem_q, rem_d;

   md_op_e           op;
   logic             op_div, op_signed, a_neg, b_neg, accept, div_zero, done;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign op        = md_op_e'(md.mdop_i);
   assign op_div    = md_is_div(op);
   assign op_signed = md_is_signed(op);
   assign a_neg     = op_signed & md.regaData[WIDTH-1];
   assign b_neg     = op_signed & md.regbData[WIDTH-1];
   assign div_zero  = op_div & (md.regbData == '0);
   assign accept    = md.start_i & ~md.cancel_i &
                      ((state_q == MDS_IDLE) || (state_q == MDS_DONE));

   md_negate #(.WIDTH(WIDTH)) u_mag_a (.en_i(a_neg), .din_i(md.regaData), .dout_o(a_mag));
   md_negate #(.WIDTH(WIDTH)) u_mag_b (.en_i(b_neg), .din_i(md.regbData), .dout_o(b_mag));

   // Multiply: acc = {partial high, remaining multiplier bits}.
   // Divide: acc low half shifts dividend bits out and quotient bits in.
   logic [WIDTH:0] mul_sum, div_shift, div_trial;
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, mcand_q};

   // Restored remainder is always below the divisor, so its top bit stays clear.
   logic unused_rem_msb;
   assign unused_rem_msb = rem_q[WIDTH];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      rem_d    = rem_q;

      case (state_q)
         MDS_IDLE: state_d = MDS_IDLE;
         MDS_CALC: begin
            cnt_d = cnt_q - CW'(1);
            if (is_div_q) begin
               rem_d = div_trial[WIDTH] ? div_shift : div_trial;
               acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            if (cnt_q == CW'(1)) state_d = MDS_DONE;
         end
         MDS_DONE: state_d = MDS_IDLE;
         default:  state_d = MDS_IDLE;
      endcase

      if (accept) begin
         state_d  = MDS_CALC;
         cnt_d    = CW'(WIDTH);
         is_div_d = op_div;
         neg_lo_d = a_neg ^ b_neg;
         neg_hi_d = a_neg & op_div;
         mcand_d  = op_div ? b_mag : a_mag;
         acc_d    = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
         rem_d    = '0;
         if (div_zero) begin
            state_d  = MDS_DONE;
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
            rem_d    = {1'b0, md.regaData};
            acc_d    = {{WIDTH{1'b0}}, {WIDTH{MD_DIV0_LO_BIT}}};
         end
      end

      if (md.cancel_i) state_d = MDS_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MDS_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
      end
   end

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   md_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.en_i(neg_lo_q), .din_i(acc_q), .dout_o(prod_fix));
   md_negate #(.WIDTH(WIDTH)) u_fix_quo (
      .en_i  (neg_lo_q),
      .din_i (acc_q[WIDTH-1:0]),
      .dout_o(quo_fix)
   );
   md_negate #(.WIDTH(WIDTH)) u_fix_rem (
      .en_i  (neg_hi_q),
      .din_i (rem_q[WIDTH-1:0]),
      .dout_o(rem_fix)
   );

   assign done       = (state_q == MDS_DONE) & ~md.cancel_i;
   assign md.done_o  = done;
   assign md.whi     = done;
   assign md.wlo     = done;
   assign md.wHiData = done ? (is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH]) : '0;
   assign md.wLoData = done ? (is_div_q ? quo_fix : prod_fix[WIDTH-1:0]) : '0;
   assign md.stall_o = ~md.cancel_i & ((state_q == MDS_CALC) |
                       (md.start_i & ((state_q == MDS_IDLE) | (state_q == MDS_DONE))));

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv at WIDTH=32: vector table plus cancel, reset
// and back-to-back sequences.
module tb_ex_muldiv;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_if #(.WIDTH(32)) bus ();
   ex_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .md(bus));

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic outs_zero(input string name);
      check({name, " done"}, {61'd0, bus.done_o, bus.whi, bus.wlo}, 64'd0);
      check({name, " data"}, {bus.wHiData, bus.wLoData}, 64'd0);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo,
                         output logic stall0, output logic seq_ok, output logic found);
      cyc();
      bus.start_i = 1'b1; bus.mdop_i = op; bus.regaData = a; bus.regbData = b;
      @(negedge clk);
      stall0 = bus.stall_o;
      seq_ok = !bus.done_o && (bus.wLoData == 0) && (bus.wHiData == 0);
      found = 1'b0; lat = 0; hi = '0; lo = '0;
      for (int c = 1; c <= 40 && !found; c++) begin
         cyc();
         bus.start_i = 1'b0;
         @(negedge clk);
         if (bus.done_o) begin
            found = 1'b1; lat = c; hi = bus.wHiData; lo = bus.wLoData;
            if (bus.stall_o || !bus.whi || !bus.wlo) seq_ok = 1'b0;
         end else if (!bus.stall_o || bus.whi || bus.wlo) begin
            seq_ok = 1'b0;
         end
      end
   endtask

   initial begin
      int          lat, c_done, c;
      logic [31:0] hi, lo;
      logic        stall0, seq_ok, found, extra;

      vecs[0]  = '{"mult_neg3x7",    2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33};
      vecs[1]  = '{"multu_maxsq",    2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
      vecs[2]  = '{"div_neg7by2",    2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
      vecs[3]  = '{"div_minbym1",    2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
      vecs[4]  = '{"divu_by0",       2'd3, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1};
      vecs[5]  = '{"div_neg8by0",    2'd2, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1};
      vecs[6]  = '{"div_7bym2",      2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
      vecs[7]  = '{"mult_minsq",     2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
      vecs[8]  = '{"mult_m1xm1",     2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33};
      vecs[9]  = '{"mult_minx1",     2'd0, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 33};
      vecs[10] = '{"multu_2p16sq",   2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33};
      vecs[11] = '{"divu_maxby16",   2'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 33};
      vecs[12] = '{"divu_5by7",      2'd3, 32'd5,        32'd7,        32'h00000005, 32'h00000000, 33};
      vecs[13] = '{"divu_1000by3",   2'd3, 32'd1000,     32'd3,        32'h00000001, 32'h0000014D, 33};

      rst = 1'b1;
      bus.start_i = 1'b0; bus.cancel_i = 1'b0; bus.mdop_i = 2'd0;
      bus.regaData = '0; bus.regbData = '0;
      repeat (3) cyc();
      rst = 1'b0;
      @(negedge clk);
      outs_zero("reset");
      check("reset stall", {63'd0, bus.stall_o}, 64'd0);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, hi, lo, stall0, seq_ok, found);
         check({vecs[i].name, " found"}, {63'd0, found}, 64'd1);
         check({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].lat));
         check({vecs[i].name, " hi"}, {32'd0, hi}, {32'd0, vecs[i].hi});
         check({vecs[i].name, " lo"}, {32'd0, lo}, {32'd0, vecs[i].lo});
         check({vecs[i].name, " stall0"}, {63'd0, stall0}, 64'd1);
         check({vecs[i].name, " strobes"}, {63'd0, seq_ok}, 64'd1);
      end

      // Cancel mid-divide, then a fresh multiply right after.
      cyc();
      bus.start_i = 1'b1; bus.mdop_i = 2'd3; bus.regaData = 32'd1000; bus.regbData = 32'd3;
      extra = 1'b0;
      for (c = 1; c <= 9; c++) begin
         cyc(); bus.start_i = 1'b0;
         @(negedge clk);
         if (bus.done_o) extra = 1'b1;
      end
      cyc(); bus.cancel_i = 1'b1;
      @(negedge clk);
      check("cancel stall", {63'd0, bus.stall_o}, 64'd0);
      outs_zero("cancel");
      cyc(); bus.cancel_i = 1'b0;
      bus.start_i = 1'b1; bus.mdop_i = 2'd1; bus.regaData = 32'd6; bus.regbData = 32'd7;
      @(negedge clk);
      check("restart stall", {63'd0, bus.stall_o}, 64'd1);
      c_done = 0; lo = '0; hi = '0;
      for (c = 12; c <= 60 && c_done == 0; c++) begin
         cyc(); bus.start_i = 1'b0;
         @(negedge clk);
         if (bus.done_o) begin c_done = c; lo = bus.wLoData; hi = bus.wHiData; end
      end
      check("cancel no done", {63'd0, extra}, 64'd0);
      check("restart done cycle", 64'(c_done), 64'd44);
      check("restart lo", {hi, lo}, 64'h2A);

      // Back-to-back: second start held during DONE.
      cyc();
      bus.start_i = 1'b1; bus.mdop_i = 2'd1; bus.regaData = 32'd6; bus.regbData = 32'd7;
      extra = 1'b0;
      for (c = 1; c <= 32; c++) begin
         cyc(); bus.start_i = 1'b0;
         @(negedge clk);
         if (bus.done_o) extra = 1'b1;
      end
      cyc();
      bus.start_i = 1'b1; bus.mdop_i = 2'd3; bus.regaData = 32'd100; bus.regbData = 32'd7;
      @(negedge clk);
      check("b2b early done", {63'd0, extra}, 64'd0);
      check("b2b first done", {63'd0, bus.done_o}, 64'd1);
      check("b2b first data", {bus.wHiData, bus.wLoData}, 64'h2A);
      check("b2b stall in done", {63'd0, bus.stall_o}, 64'd1);
      c_done = 0;
      for (c = 34; c <= 80 && c_done == 0; c++) begin
         cyc(); bus.start_i = 1'b0;
         @(negedge clk);
         if (bus.done_o) begin c_done = c; lo = bus.wLoData; hi = bus.wHiData; end
      end
      check("b2b second cycle", 64'(c_done), 64'd66);
      check("b2b second data", {hi, lo}, {32'd2, 32'd14});

      // Cancel in DONE beats a same-cycle start and hides the strobe.
      cyc();
      bus.start_i = 1'b1; bus.mdop_i = 2'd1; bus.regaData = 32'd2; bus.regbData = 32'd3;
      for (c = 1; c <= 32; c++) begin
         cyc(); bus.start_i = 1'b0;
      end
      cyc();
      bus.cancel_i = 1'b1; bus.start_i = 1'b1; bus.regaData = 32'd4; bus.regbData = 32'd4;
      @(negedge clk);
      outs_zero("cancel in done");
      check("cancel in done stall", {63'd0, bus.stall_o}, 64'd0);
      cyc(); bus.cancel_i = 1'b0; bus.start_i = 1'b0;
      @(negedge clk);
      check("after cancel stall", {63'd0, bus.stall_o}, 64'd0);
      extra = 1'b0;
      for (c = 0; c < 40; c++) begin
         cyc();
         @(negedge clk);
         if (bus.done_o || bus.stall_o) extra = 1'b1;
      end
      check("after cancel quiet", {63'd0, extra}, 64'd0);

      // Reset in the middle of CALC.
      cyc();
      bus.start_i = 1'b1; bus.mdop_i = 2'd0; bus.regaData = 32'd5; bus.regbData = 32'd5;
      for (c = 1; c <= 4; c++) begin
         cyc(); bus.start_i = 1'b0;
      end
      cyc(); rst = 1'b1;
      @(negedge clk);
      check("rst cycle stall", {63'd0, bus.stall_o}, 64'd1);
      cyc(); rst = 1'b0;
      @(negedge clk);
      outs_zero("after rst");
      check("after rst stall", {63'd0, bus.stall_o}, 64'd0);
      extra = 1'b0;
      for (c = 0; c < 40; c++) begin
         cyc();
         @(negedge clk);
         if (bus.done_o || bus.stall_o) extra = 1'b1;
      end
      check("after rst quiet", {63'd0, extra}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
